dpram_sync: RTL and testbench

Parametrised synchronous true dual-port RAM, the successor to the team's 8x16 asynchronous dual-port RAM. Two independent read/write ports share one clock and one storage array. Compared with the earlier block it adds:
- registered reads with a valid strobe;
- a defined read-during-write mode;
- deterministic write-collision arbitration with a saturating collision counter;
- a post-reset memory-clear sequence.

It sits between two masters (e.g. a datapath and a control/host port) that need shared scratch storage.

---
 rtl/dpram_pkg.sv | 15 +
 rtl/dpram_if.sv | 15 +
 rtl/dpram_rdport.sv | 62 ++++++
 rtl/dpram_sync.sv | 128 ++++++++++++
 tb/tb_dpram_sync.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_pkg.sv
// Shared types and constants for the synchronous dual-port RAM.
package dpram_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } dpram_state_e;

  localparam int unsigned RDW_OLD    = 0;
  localparam int unsigned RDW_NEW    = 1;
  localparam int unsigned COLL_CNT_W = 8;

  localparam logic [COLL_CNT_W-1:0] COLL_MAX = '1;

endpackage

// File: rtl/dpram_if.sv
// One RAM access port: request/write/address/data in, registered read data and strobe out.
interface dpram_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rvalid;

  modport master (output req, we, addr, din, input dout, rvalid);
  modport slave  (input req, we, addr, din, output dout, rvalid);
endinterface

// File: rtl/dpram_rdport.sv
// Per-port read capture, read-during-write mux and rvalid generation.
// DPRAM_OUTREG_EN adds one more output register stage (2-cycle read latency).
module dpram_rdport
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RDW_MODE = RDW_OLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid
);

  localparam bit WrFirst = (RDW_MODE == RDW_NEW);

  logic [DATA_W-1:0] cap_q;
  logic              cap_vld_q;

  // dout holds its value until a new read (or write-first write) lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      cap_vld_q <= rd_en | (wr_en & WrFirst);
      if (rd_en) begin
        cap_q <= rd_data;
      end else if (wr_en && WrFirst) begin
        cap_q <= wr_data;
      end
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [DATA_W-1:0] out_q;
  logic              out_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= cap_vld_q;
      if (cap_vld_q) begin
        out_q <= cap_q;
      end
    end
  end

  assign dout   = out_q;
  assign rvalid = out_vld_q;
`else
  assign dout   = cap_q;
  assign rvalid = cap_vld_q;
`endif

endmodule

// File: rtl/dpram_sync.sv
// Synchronous true dual-port RAM with post-reset clear, A-wins write arbitration
// and a saturating collision counter. Optional output register: DPRAM_OUTREG_EN.
module dpram_sync
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned RDW_MODE = RDW_OLD
) (
  input  logic                  clk,
  input  logic                  rst,
  dpram_if.slave                port_a,
  dpram_if.slave                port_b,
  output logic                  ready,
  output logic [COLL_CNT_W-1:0] coll_cnt,
  input  logic                  coll_clr
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  dpram_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [COLL_CNT_W-1:0] coll_cnt_q, coll_cnt_d;

  logic accept;
  logic rd_a, rd_b, wr_a, wr_b, wr_req_b, coll;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign ready  = (state_q == RUN);
  // A still-high ready during the reset cycle must not let a request through.
  assign accept = ready & ~rst;

  assign rd_a     = accept & port_a.req & ~port_a.we;
  assign rd_b     = accept & port_b.req & ~port_b.we;
  assign wr_a     = accept & port_a.req & port_a.we;
  assign wr_req_b = accept & port_b.req & port_b.we;
  assign coll     = wr_a & wr_req_b & (port_a.addr == port_b.addr);
  assign wr_b     = wr_req_b & ~coll;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        mem_q[clr_cnt_q] <= '0;
      end
      if (wr_b) begin
        mem_q[port_b.addr] <= port_b.din;
      end
      if (wr_a) begin
        mem_q[port_a.addr] <= port_a.din;
      end
    end
  end

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (coll_clr) begin
      coll_cnt_d = '0;
    end else if (coll && (coll_cnt_q != COLL_MAX)) begin
      coll_cnt_d = coll_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_cnt_q <= '0;
    end else begin
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign coll_cnt = coll_cnt_q;

  dpram_rdport #(
    .DATA_W   (DATA_W),
    .RDW_MODE (RDW_MODE)
  ) u_rdport_a (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_a),
    .wr_en   (wr_a),
    .rd_data (mem_q[port_a.addr]),
    .wr_data (port_a.din),
    .dout    (port_a.dout),
    .rvalid  (port_a.rvalid)
  );

  dpram_rdport #(
    .DATA_W   (DATA_W),
    .RDW_MODE (RDW_MODE)
  ) u_rdport_b (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_b),
    .wr_en   (wr_req_b),
    .rd_data (mem_q[port_b.addr]),
    .wr_data (port_b.din),
    .dout    (port_b.dout),
    .rvalid  (port_b.rvalid)
  );

endmodule

// File: tb/tb_dpram_sync.sv
// Bench for dpram_sync: directed checks on a 16x8 read-old instance, randomized
// traffic on a 32x64 write-first instance against an array-based reference model.
module tb_dpram_sync;
  import dpram_pkg::*;

`ifdef DPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dpram_if #(.DATA_W(16), .ADDR_W(3)) ia ();
  dpram_if #(.DATA_W(16), .ADDR_W(3)) ib ();
  dpram_if #(.DATA_W(32), .ADDR_W(6)) pa ();
  dpram_if #(.DATA_W(32), .ADDR_W(6)) pb ();

  logic       ready0, ready1, clr0, clr1;
  logic [7:0] cc0, cc1;

  dpram_sync #(.DATA_W(16), .DEPTH(8), .RDW_MODE(RDW_OLD)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .port_a   (ia),
    .port_b   (ib),
    .ready    (ready0),
    .coll_cnt (cc0),
    .coll_clr (clr0)
  );

  dpram_sync #(.DATA_W(32), .DEPTH(64), .RDW_MODE(RDW_NEW)) u_dut_p (
    .clk      (clk),
    .rst      (rst),
    .port_a   (pa),
    .port_b   (pb),
    .ready    (ready1),
    .coll_cnt (cc1),
    .coll_clr (clr1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ia.req = 1'b0; ia.we = 1'b0; ia.addr = '0; ia.din = '0;
    ib.req = 1'b0; ib.we = 1'b0; ib.addr = '0; ib.din = '0;
    pa.req = 1'b0; pa.we = 1'b0; pa.addr = '0; pa.din = '0;
    pb.req = 1'b0; pb.we = 1'b0; pb.addr = '0; pb.din = '0;
    clr0 = 1'b0; clr1 = 1'b0;
  endtask

  // Call right after rst is released: 8 / 64 cycles of ready=0, then 1.
  task automatic check_init(input string tag);
    for (int i = 0; i <= 64; i++) begin
      check_eq({tag, " ready d8"}, 32'(ready0), 32'(i >= 8));
      check_eq({tag, " ready d64"}, 32'(ready1), 32'(i >= 64));
      if (i < 64) tick();
    end
  endtask

  task automatic wr_a0(input logic [2:0] addr, input logic [15:0] data);
    ia.req = 1'b1; ia.we = 1'b1; ia.addr = addr; ia.din = data;
    tick();
    ia.req = 1'b0; ia.we = 1'b0;
  endtask

  task automatic rd_a0(input logic [2:0] addr, input logic [15:0] exp, input string tag);
    ia.req = 1'b1; ia.we = 1'b0; ia.addr = addr;
    tick();
    ia.req = 1'b0;
    repeat (LAT - 1) tick();
    check_eq({tag, " rvalid_a"}, 32'(ia.rvalid), 32'd1);
    check_eq({tag, " dout_a"}, 32'(ia.dout), 32'(exp));
  endtask

  task automatic rd_b0(input logic [2:0] addr, input logic [15:0] exp, input string tag);
    ib.req = 1'b1; ib.we = 1'b0; ib.addr = addr;
    tick();
    ib.req = 1'b0;
    repeat (LAT - 1) tick();
    check_eq({tag, " rvalid_b"}, 32'(ib.rvalid), 32'd1);
    check_eq({tag, " dout_b"}, 32'(ib.dout), 32'(exp));
  endtask

  // Reference model state for the random phase.
  logic [31:0] mem_m [64];
  logic [32:0] pipe_a [$];
  logic [32:0] pipe_b [$];
  logic [31:0] hold_a, hold_b;
  logic [7:0]  cc_m;
  logic [32:0] ea, eb;
  logic        r_req_a, r_we_a, r_req_b, r_we_b, r_clr, r_coll;
  logic [5:0]  r_addr_a, r_addr_b;
  logic [31:0] r_din_a, r_din_b;

  function automatic logic [5:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 6'($urandom_range(0, 3));
    return 6'($urandom_range(0, 63));
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    check_eq("reset ready", 32'(ready0), 32'd0);
    check_eq("reset dout_a", 32'(ia.dout), 32'd0);
    check_eq("reset rvalid_b", 32'(ib.rvalid), 32'd0);
    check_eq("reset coll_cnt", 32'(cc0), 32'd0);
    rst = 1'b0;
    check_init("init");
    for (int a = 0; a < 8; a++) begin
      rd_a0(3'(a), 16'h0000, "init clear");
      rd_b0(3'(a), 16'h0000, "init clear");
    end

    // Dirty every word, then reset again part-way through INIT.
    for (int a = 0; a < 8; a++) wr_a0(3'(a), 16'h1000 + 16'(a));
    rd_b0(3'd6, 16'h1006, "prefill");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_init("reinit");
    for (int a = 0; a < 8; a++) rd_a0(3'(a), 16'h0000, "reinit clear");

    // Write on A, read on B the following cycle.
    wr_a0(3'd3, 16'hBEEF);
    rd_b0(3'd3, 16'hBEEF, "basic");

    // Dual-write collision: A wins, counter counts and saturates.
    ia.req = 1'b1; ia.we = 1'b1; ia.addr = 3'd5; ia.din = 16'h1111;
    ib.req = 1'b1; ib.we = 1'b1; ib.addr = 3'd5; ib.din = 16'h2222;
    tick();
    idle_all();
    check_eq("coll one", 32'(cc0), 32'd1);
    rd_a0(3'd5, 16'h1111, "coll winner");
    ia.req = 1'b1; ia.we = 1'b1; ia.addr = 3'd5;
    ib.req = 1'b1; ib.we = 1'b1; ib.addr = 3'd5;
    repeat (300) tick();
    check_eq("coll saturate", 32'(cc0), 32'd255);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    check_eq("coll clr wins", 32'(cc0), 32'd0);
    tick();
    idle_all();
    check_eq("coll after clr", 32'(cc0), 32'd1);

    // Cross-port read-during-write returns old data.
    wr_a0(3'd2, 16'hAAAA);
    ia.req = 1'b1; ia.we = 1'b1; ia.addr = 3'd2; ia.din = 16'h5555;
    ib.req = 1'b1; ib.we = 1'b0; ib.addr = 3'd2;
    tick();
    idle_all();
    repeat (LAT - 1) tick();
    check_eq("xport rvalid_b", 32'(ib.rvalid), 32'd1);
    check_eq("xport old", 32'(ib.dout), 32'hAAAA);
    rd_b0(3'd2, 16'h5555, "xport new");

    // Same-port write, read-old build: no strobe, dout untouched.
    wr_a0(3'd1, 16'h0F0F);
    rd_a0(3'd1, 16'h0F0F, "rdw0 pre");
    wr_a0(3'd1, 16'hF0F0);
    repeat (LAT - 1) tick();
    check_eq("rdw0 rvalid_a", 32'(ia.rvalid), 32'd0);
    check_eq("rdw0 dout_a", 32'(ia.dout), 32'h0F0F);
    rd_a0(3'd1, 16'hF0F0, "rdw0 stored");

    // Same-port write, write-first build: dout takes din with a strobe.
    pa.req = 1'b1; pa.we = 1'b1; pa.addr = 6'd1; pa.din = 32'h0000_0F0F;
    tick();
    pa.din = 32'h0000_F0F0;
    tick();
    pa.req = 1'b0; pa.we = 1'b0;
    repeat (LAT - 1) tick();
    check_eq("rdw1 rvalid_a", 32'(pa.rvalid), 32'd1);
    check_eq("rdw1 dout_a", pa.dout, 32'h0000_F0F0);

    // Random concurrent traffic on the 32x64 instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (64) tick();
    check_eq("rand ready", 32'(ready1), 32'd1);
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    hold_a = '0;
    hold_b = '0;
    cc_m   = '0;
    pipe_a.delete();
    pipe_b.delete();
    repeat (LAT - 1) begin
      pipe_a.push_back(33'h0);
      pipe_b.push_back(33'h0);
    end
    for (int n = 0; n < 600; n++) begin
      r_req_a  = ($urandom_range(0, 3) != 0);
      r_we_a   = 1'($urandom_range(0, 1));
      r_addr_a = rand_addr();
      r_din_a  = $urandom;
      r_req_b  = ($urandom_range(0, 3) != 0);
      r_we_b   = 1'($urandom_range(0, 1));
      r_addr_b = rand_addr();
      r_din_b  = $urandom;
      r_clr    = ($urandom_range(0, 31) == 0);
      pa.req = r_req_a; pa.we = r_we_a; pa.addr = r_addr_a; pa.din = r_din_a;
      pb.req = r_req_b; pb.we = r_we_b; pb.addr = r_addr_b; pb.din = r_din_b;
      clr1 = r_clr;

      // Reads see pre-write contents; write-first writes echo their own data.
      if (!r_req_a)    pipe_a.push_back(33'h0);
      else if (r_we_a) pipe_a.push_back({1'b1, r_din_a});
      else             pipe_a.push_back({1'b1, mem_m[r_addr_a]});
      if (!r_req_b)    pipe_b.push_back(33'h0);
      else if (r_we_b) pipe_b.push_back({1'b1, r_din_b});
      else             pipe_b.push_back({1'b1, mem_m[r_addr_b]});
      r_coll = r_req_a && r_we_a && r_req_b && r_we_b && (r_addr_a == r_addr_b);
      if (r_req_b && r_we_b && !r_coll) mem_m[r_addr_b] = r_din_b;
      if (r_req_a && r_we_a)            mem_m[r_addr_a] = r_din_a;
      if (r_clr)                        cc_m = 8'd0;
      else if (r_coll && cc_m != 8'd255) cc_m = cc_m + 8'd1;

      tick();
      ea = pipe_a.pop_front();
      eb = pipe_b.pop_front();
      if (ea[32]) hold_a = ea[31:0];
      if (eb[32]) hold_b = eb[31:0];
      check_eq("rand rvalid_a", 32'(pa.rvalid), 32'(ea[32]));
      check_eq("rand dout_a", pa.dout, hold_a);
      check_eq("rand rvalid_b", 32'(pb.rvalid), 32'(eb[32]));
      check_eq("rand dout_b", pb.dout, hold_b);
      check_eq("rand coll_cnt", 32'(cc1), 32'(cc_m));
    end
    idle_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
